// File: rtl/status_capture.sv
// Status capture: synchronise two input banks, merge per bit, queue timestamped change events.
// Latency: input change to evt_valid is SYNC_STAGES+1 edges; FIFO head is first-word-fall-through.
// Backpressure: evt_ready low holds the head; a push into a full FIFO is dropped and counted.
// Optional feature: define STATUS_CAPTURE_PARITY_EN to add per-entry even parity on evt_par.
module status_capture #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TS_W        = 16,
    parameter int DROP_W      = 8
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              enable,
    input  logic              snap,
    input  logic              clear,
    input  logic [WIDTH-1:0]  sel_mask,
    input  logic [WIDTH-1:0]  pri_in,
    input  logic [WIDTH-1:0]  alt_in,
    output logic [WIDTH-1:0]  status,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [WIDTH-1:0]  evt_data,
    output logic [TS_W-1:0]   evt_ts,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
`ifdef STATUS_CAPTURE_PARITY_EN
    ,
    output logic              evt_par
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] pri_sync_q, pri_sync_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] alt_sync_q, alt_sync_d;
    logic [WIDTH-1:0]  pri_s, alt_s, mixed;
    logic [WIDTH-1:0]  status_q, status_d, prev_q, prev_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [WIDTH-1:0]  dat_mem_q [DEPTH];
    logic [WIDTH-1:0]  dat_mem_d [DEPTH];
    logic [TS_W-1:0]   ts_mem_q  [DEPTH];
    logic [TS_W-1:0]   ts_mem_d  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              push, pop, full, do_write, drop;
`ifdef STATUS_CAPTURE_PARITY_EN
    logic              par_mem_q [DEPTH];
    logic              par_mem_d [DEPTH];
`endif

    // Synchroniser chains shift the raw inputs one stage per cycle
    always_comb begin
        pri_sync_d    = pri_sync_q;
        alt_sync_d    = alt_sync_q;
        pri_sync_d[0] = pri_in;
        alt_sync_d[0] = alt_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            pri_sync_d[i] = pri_sync_q[i-1];
            alt_sync_d[i] = alt_sync_q[i-1];
        end
    end

    assign pri_s = pri_sync_q[SYNC_STAGES-1];
    assign alt_s = alt_sync_q[SYNC_STAGES-1];
    assign mixed = (pri_s & sel_mask) | (alt_s & ~sel_mask);

    // Flow control: a pop frees a slot in the same cycle, so full+pop still accepts the push
    assign full     = (count_q == FULL_CNT);
    assign evt_valid = (count_q != '0);
    assign pop      = evt_valid & evt_ready;
    assign push     = snap | (enable & (mixed != prev_q));
    assign do_write = push & (~full | pop);
    assign drop     = push & full & ~pop;

    // Next-state for merge tracking, timestamp, FIFO storage and drop accounting
    always_comb begin
        status_d   = mixed;
        prev_d     = mixed;
        ts_d       = ts_q + TS_W'(1);
        dat_mem_d  = dat_mem_q;
        ts_mem_d   = ts_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
`ifdef STATUS_CAPTURE_PARITY_EN
        par_mem_d  = par_mem_q;
`endif
        if (do_write) begin
            dat_mem_d[wr_ptr_q] = mixed;
            ts_mem_d[wr_ptr_q]  = ts_q;
`ifdef STATUS_CAPTURE_PARITY_EN
            par_mem_d[wr_ptr_q] = ^{mixed, ts_q};
`endif
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_write, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as clear wins: the new drop is the first one counted
        if (drop) begin
            overflow_d = 1'b1;
            if (clear) begin
                drop_cnt_d = DROP_W'(1);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end else if (clear) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    // State registers; reset flushes the FIFO and all tracking state at once
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            pri_sync_q <= '0;
            alt_sync_q <= '0;
            status_q   <= '0;
            prev_q     <= '0;
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_mem_q[i] <= '0;
                ts_mem_q[i]  <= '0;
`ifdef STATUS_CAPTURE_PARITY_EN
                par_mem_q[i] <= 1'b0;
`endif
            end
        end else begin
            pri_sync_q <= pri_sync_d;
            alt_sync_q <= alt_sync_d;
            status_q   <= status_d;
            prev_q     <= prev_d;
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            dat_mem_q  <= dat_mem_d;
            ts_mem_q   <= ts_mem_d;
`ifdef STATUS_CAPTURE_PARITY_EN
            par_mem_q  <= par_mem_d;
`endif
        end
    end

    assign status   = status_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
    // Head reads zero when empty so idle outputs are clean
    assign evt_data = evt_valid ? dat_mem_q[rd_ptr_q] : '0;
    assign evt_ts   = evt_valid ? ts_mem_q[rd_ptr_q]  : '0;
`ifdef STATUS_CAPTURE_PARITY_EN
    assign evt_par  = evt_valid ? par_mem_q[rd_ptr_q] : 1'b0;
`endif

endmodule

// File: tb/tb_status_capture.sv
// Directed bench for status_capture (WIDTH=8, DEPTH=4, SYNC_STAGES=2, TS_W=4).
// Inputs change #1 after a rising edge; outputs are sampled at the same point.
// Expected timestamps come from a bench cycle counter that restarts at reset.
module tb_status_capture;

    localparam int W   = 8;
    localparam int D   = 4;
    localparam int TSW = 4;
    localparam int DW  = 8;

    logic          sysclk = 1'b0;
    logic          reset;
    logic          enable, snap, clear, evt_ready;
    logic [W-1:0]  sel_mask, pri_in, alt_in;
    logic [W-1:0]  status, evt_data;
    logic          evt_valid, overflow;
    logic [TSW-1:0] evt_ts;
    logic [DW-1:0] drop_cnt;
`ifdef STATUS_CAPTURE_PARITY_EN
    logic          evt_par;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [TSW-1:0] cyc;
    logic [W-1:0]   dat_exp [6];
    logic [TSW-1:0] ts_exp  [6];

    status_capture #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(2), .TS_W(TSW), .DROP_W(DW)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .enable    (enable),
        .snap      (snap),
        .clear     (clear),
        .sel_mask  (sel_mask),
        .pri_in    (pri_in),
        .alt_in    (alt_in),
        .status    (status),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .evt_ts    (evt_ts),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
`ifdef STATUS_CAPTURE_PARITY_EN
        ,
        .evt_par   (evt_par)
`endif
    );

    always #5 sysclk = ~sysclk;

    // Reference timestamp: number of edges since reset release, modulo 2^TSW
    always @(posedge sysclk or negedge reset) begin
        if (!reset) cyc <= '0;
        else        cyc <= cyc + 1'b1;
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; snap = 1'b0; clear = 1'b0; evt_ready = 1'b0;
        sel_mask = 8'hFF; pri_in = 8'hFF; alt_in = 8'h00;
        tick_n(3);
        n_total++; if (evt_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", evt_valid); else n_pass++;
        n_total++; if (status !== 8'h00) $display("FAIL reset_status got %h want 00", status); else n_pass++;
        n_total++; if (drop_cnt !== 8'h00) $display("FAIL reset_drop got %h want 00", drop_cnt); else n_pass++;
        n_total++; if (evt_data !== 8'h00 || evt_ts !== 4'h0) $display("FAIL reset_head got %h/%h want 00/0", evt_data, evt_ts); else n_pass++;
        reset = 1'b1;
        tick_n(4);
        pri_in = 8'h00;
        tick_n(4);
    endtask

    task automatic test_latency();
        logic [TSW-1:0] t;
        enable = 1'b1;
        pri_in = 8'h5A;
        t = cyc + 4'd2;
        tick_n(2);
        n_total++; if (evt_valid !== 1'b0) $display("FAIL lat_early got %b want 0", evt_valid); else n_pass++;
        tick();
        n_total++; if (evt_valid !== 1'b1) $display("FAIL lat_valid got %b want 1", evt_valid); else n_pass++;
        n_total++; if (evt_data !== 8'h5A) $display("FAIL lat_data got %h want 5a", evt_data); else n_pass++;
        n_total++; if (evt_ts !== t) $display("FAIL lat_ts got %h want %h", evt_ts, t); else n_pass++;
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        n_total++; if (evt_valid !== 1'b0) $display("FAIL lat_pop got %b want 0", evt_valid); else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            pri_in     = 8'(i + 1);
            dat_exp[i] = 8'(i + 1);
            ts_exp[i]  = cyc + 4'd2;
            tick_n(2);
        end
        tick_n(3);
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else n_pass++;
        n_total++; if (drop_cnt !== 8'd1) $display("FAIL ovf_drop got %0d want 1", drop_cnt); else n_pass++;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_total++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) $display("FAIL clr got ovf=%b drop=%0d want 0/0", overflow, drop_cnt); else n_pass++;
        n_total++; if (evt_valid !== 1'b1 || evt_data !== 8'h01 || evt_ts !== ts_exp[0])
            $display("FAIL clr_head got %b/%h/%h want 1/01/%h", evt_valid, evt_data, evt_ts, ts_exp[0]); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        pri_in     = 8'h06;
        dat_exp[5] = 8'h06;
        ts_exp[5]  = cyc + 4'd2;
        tick_n(2);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        n_total++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) $display("FAIL fpp_drop got ovf=%b drop=%0d want 0/0", overflow, drop_cnt); else n_pass++;
        n_total++; if (evt_data !== 8'h02) $display("FAIL fpp_head got %h want 02", evt_data); else n_pass++;
        evt_ready = 1'b1;
        for (int k = 1; k < 6; k++) begin
            if (k == 4) continue;
            n_total++; if (evt_valid !== 1'b1 || evt_data !== dat_exp[k] || evt_ts !== ts_exp[k])
                $display("FAIL drain_%0d got %b/%h/%h want 1/%h/%h", k, evt_valid, evt_data, evt_ts, dat_exp[k], ts_exp[k]); else n_pass++;
            tick();
        end
        evt_ready = 1'b0;
        n_total++; if (evt_valid !== 1'b0) $display("FAIL drain_empty got %b want 0", evt_valid); else n_pass++;
    endtask

    task automatic test_enable_snap();
        logic [TSW-1:0] t;
        enable = 1'b0;
        pri_in = 8'h07; tick_n(2);
        pri_in = 8'h08; tick_n(2);
        pri_in = 8'h09; tick_n(5);
        n_total++; if (evt_valid !== 1'b0) $display("FAIL dis_noevt got %b want 0", evt_valid); else n_pass++;
        snap = 1'b1;
        t = cyc;
        tick();
        snap = 1'b0;
        n_total++; if (evt_valid !== 1'b1 || evt_data !== 8'h09 || evt_ts !== t)
            $display("FAIL snap got %b/%h/%h want 1/09/%h", evt_valid, evt_data, evt_ts, t); else n_pass++;
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        n_total++; if (evt_valid !== 1'b0) $display("FAIL snap_once got %b want 0", evt_valid); else n_pass++;
        enable = 1'b1;
        tick_n(4);
        n_total++; if (evt_valid !== 1'b0) $display("FAIL reen_stale got %b want 0", evt_valid); else n_pass++;
    endtask

    task automatic test_merge();
        enable = 1'b0;
        sel_mask = 8'h0F; pri_in = 8'hAA; alt_in = 8'h55;
        tick_n(4);
        n_total++; if (status !== 8'h5A) $display("FAIL merge_0f got %h want 5a", status); else n_pass++;
        sel_mask = 8'hF0;
        tick();
        n_total++; if (status !== 8'hA5) $display("FAIL merge_f0 got %h want a5", status); else n_pass++;
    endtask

    task automatic test_ts_wrap();
        int guard = 0;
        logic [TSW-1:0] w_ts  [3];
        logic           w_par [3];
        w_ts[0] = 4'd14; w_ts[1] = 4'd15; w_ts[2] = 4'd0;
        w_par[0] = 1'b1; w_par[1] = 1'b0; w_par[2] = 1'b0;
        while (cyc != 4'd14 && guard < 40) begin
            tick();
            guard++;
        end
        n_total++; if (guard >= 40) $display("FAIL wrap_wait got timeout want cyc 14"); else n_pass++;
        snap = 1'b1;
        tick_n(3);
        snap = 1'b0;
        evt_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_total++; if (evt_valid !== 1'b1 || evt_data !== 8'hA5 || evt_ts !== w_ts[k])
                $display("FAIL wrap_%0d got %b/%h/%h want 1/a5/%h", k, evt_valid, evt_data, evt_ts, w_ts[k]); else n_pass++;
`ifdef STATUS_CAPTURE_PARITY_EN
            n_total++; if (evt_par !== w_par[k]) $display("FAIL par_%0d got %b want %b", k, evt_par, w_par[k]); else n_pass++;
`endif
            tick();
        end
        evt_ready = 1'b0;
        n_total++; if (evt_valid !== 1'b0) $display("FAIL wrap_empty got %b want 0", evt_valid); else n_pass++;
    endtask

    task automatic test_reset_flush();
        snap = 1'b1;
        tick();
        snap = 1'b0;
        n_total++; if (evt_valid !== 1'b1) $display("FAIL flush_pre got %b want 1", evt_valid); else n_pass++;
        reset = 1'b0;
        #2;
        n_total++; if (evt_valid !== 1'b0 || evt_data !== 8'h00 || status !== 8'h00)
            $display("FAIL flush got %b/%h/%h want 0/00/00", evt_valid, evt_data, status); else n_pass++;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_overflow();
        test_full_push_pop();
        test_enable_snap();
        test_merge();
        test_ts_wrap();
        test_reset_flush();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

endmodule
